qspi_rx_datapath: RTL and testbench

//  Bit counter, receive sampler and burst tracker on the QSPI side, driven by the QSPI controller FSM.

---
 rtl/qspi_rx_datapath.sv | 155 +++++++++++++++
 tb/tb_qspi_rx_datapath.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_rx_datapath.sv
// -----------------------------------------------------------------------------
// qspi_rx_datapath
//   QSPI-side datapath that works alongside the controller FSM. It contains
//   three pieces of logic:
//     - Phase bit counter. It returns count_done_out on the last sclk cycle of
//       the current phase (command, address, dummy or data).
//     - Receive sampler. It shifts the io lines into a 32-bit word, with the
//       first bit received ending up in the MSB.
//     - Burst word counter. It returns burst_comp_out once the burst has been
//       fully consumed or produced.
//   All state lives in the single sclk_in domain.
//
// Ports
//   sclk_in                QSPI clock; all state updates on the rising edge
//   rst_n                  asynchronous, active-low reset
//   start_count_in         phase counter enable
//   set_count_lim_in       phase select: 00 cmd/status, 01 addr, 10 dummy, 11 data
//   addr_of_4B_in          1: 32-bit address, 0: 24-bit address
//   use_1/2/4_io_lines_in  bus width select (4 wins over 2, 2 wins over 1)
//   data_sample_reg_en_in  shift the io sample into the rx word this cycle
//   sel_sample_1_line_in   force 1-line sampling on io[1] (status read)
//   io_in[3:0]             synchronised io line values
//   load_burst_in          load the burst counter from burst_len_in
//   burst_len_in           number of words in the burst
//   burst_count_en_in      one burst word consumed or produced
//   count_done_out         final cycle of the current phase (combinational)
//   rx_word_out[31:0]      sampled receive word
//   burst_comp_out         burst counter is zero (registered state only)
// -----------------------------------------------------------------------------
module qspi_rx_datapath #(
  parameter int DUMMY_CYCLES = 8,
  parameter int BURST_W      = 8
) (
  input  logic               sclk_in,
  input  logic               rst_n,
  input  logic               start_count_in,
  input  logic [1:0]         set_count_lim_in,
  input  logic               addr_of_4B_in,
  input  logic               use_1_io_lines_in,
  input  logic               use_2_io_lines_in,
  input  logic               use_4_io_lines_in,
  input  logic               data_sample_reg_en_in,
  input  logic               sel_sample_1_line_in,
  input  logic [3:0]         io_in,
  input  logic               load_burst_in,
  input  logic [BURST_W-1:0] burst_len_in,
  input  logic               burst_count_en_in,
  output logic               count_done_out,
  output logic [31:0]        rx_word_out,
  output logic               burst_comp_out
);

  typedef enum logic [1:0] {
    LIM_CMD   = 2'b00,
    LIM_ADDR  = 2'b01,
    LIM_DUMMY = 2'b10,
    LIM_DATA  = 2'b11
  } lim_sel_e;

  typedef enum logic [1:0] {
    LINES_1,
    LINES_2,
    LINES_4
  } line_mode_e;

  logic [5:0]         r_cnt;
  logic [31:0]        r_rx_word;
  logic [BURST_W-1:0] r_bcnt;

  line_mode_e         w_mode;
  logic [5:0]         w_lim_m1;
  logic               w_done;
  logic [31:0]        w_base;
  logic [31:0]        w_rx_next;

  // Decode the bus width. When no width flag is set, the bus falls back to
  // single-line mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise a latch is inferred.
    w_mode = LINES_1;
    if (use_4_io_lines_in)      w_mode = LINES_4;
    else if (use_2_io_lines_in) w_mode = LINES_2;
  end

  // Last count value of the phase, expressed as LIM-1.
  always_comb begin
    w_lim_m1 = 6'd7;
    case (lim_sel_e'(set_count_lim_in))
      LIM_CMD:   w_lim_m1 = 6'd7;  // command on io0 and status on io1: always 8 bits
      LIM_ADDR: begin
        case (w_mode)
          LINES_4: w_lim_m1 = addr_of_4B_in ? 6'd7  : 6'd5;
          LINES_2: w_lim_m1 = addr_of_4B_in ? 6'd15 : 6'd11;
          default: w_lim_m1 = addr_of_4B_in ? 6'd31 : 6'd23;
        endcase
      end
      LIM_DUMMY: w_lim_m1 = 6'(DUMMY_CYCLES - 1);
      LIM_DATA: begin
        case (w_mode)
          LINES_4: w_lim_m1 = 6'd7;
          LINES_2: w_lim_m1 = 6'd15;
          default: w_lim_m1 = 6'd31;
        endcase
      end
      default:   w_lim_m1 = 6'd7;
    endcase
  end

  // The compare uses >= so that shortening the limit in mid-phase ends the
  // phase at once, instead of letting the counter run past the new limit.
  assign w_done         = start_count_in && (r_cnt >= w_lim_m1);
  assign count_done_out = w_done;

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset, so every flop reads the pre-edge value of the others.
  always_ff @(posedge sclk_in or negedge rst_n) begin
    if (!rst_n)                        r_cnt <= '0;
    else if (!start_count_in || w_done) r_cnt <= '0;
    else                               r_cnt <= r_cnt + 6'd1;
  end

  // The first sample of a phase (cnt==0) starts from an empty word, so a
  // stale word from an earlier phase never leaks into the new one.
  assign w_base = (r_cnt == 6'd0) ? 32'b0 : r_rx_word;

  always_comb begin
    w_rx_next = {w_base[30:0], io_in[1]};
    if (!sel_sample_1_line_in) begin
      case (w_mode)
        LINES_4: w_rx_next = {w_base[27:0], io_in[3:0]};
        LINES_2: w_rx_next = {w_base[29:0], io_in[1:0]};
        default: w_rx_next = {w_base[30:0], io_in[1]};
      endcase
    end
  end

  always_ff @(posedge sclk_in or negedge rst_n) begin
    if (!rst_n)                     r_rx_word <= '0;
    else if (data_sample_reg_en_in) r_rx_word <= w_rx_next;
  end

  assign rx_word_out = r_rx_word;

  // A load takes priority over a decrement, and a decrement at zero
  // saturates instead of wrapping.
  always_ff @(posedge sclk_in or negedge rst_n) begin
    if (!rst_n)                                     r_bcnt <= '0;
    else if (load_burst_in)                         r_bcnt <= burst_len_in;
    else if (burst_count_en_in && (r_bcnt != '0))   r_bcnt <= r_bcnt - 1'b1;
  end

  assign burst_comp_out = (r_bcnt == '0);

endmodule

// File: tb/tb_qspi_rx_datapath.sv
// -----------------------------------------------------------------------------
// tb_qspi_rx_datapath
//   Self-checking bench for qspi_rx_datapath.
//   A table of phase-limit vectors runs each phase twice back to back. The
//   expected cycle of each count_done_out pulse is pushed to a queue when the
//   phase starts, and the entry is popped when the DUT asserts done. A set of
//   hand-written sequences then covers sampling, status read, the burst
//   counter, a mid-phase limit change, chained phases and a mid-phase reset.
// -----------------------------------------------------------------------------
module tb_qspi_rx_datapath;

  localparam int BURST_W = 8;

  logic               sclk_in = 1'b0;
  logic               rst_n;
  logic               start_count_in;
  logic [1:0]         set_count_lim_in;
  logic               addr_of_4B_in;
  logic               use_1_io_lines_in;
  logic               use_2_io_lines_in;
  logic               use_4_io_lines_in;
  logic               data_sample_reg_en_in;
  logic               sel_sample_1_line_in;
  logic [3:0]         io_in;
  logic               load_burst_in;
  logic [BURST_W-1:0] burst_len_in;
  logic               burst_count_en_in;
  logic               count_done_out;
  logic [31:0]        rx_word_out;
  logic               burst_comp_out;

  qspi_rx_datapath #(.DUMMY_CYCLES(8), .BURST_W(BURST_W)) dut (
    .sclk_in               (sclk_in),
    .rst_n                 (rst_n),
    .start_count_in        (start_count_in),
    .set_count_lim_in      (set_count_lim_in),
    .addr_of_4B_in         (addr_of_4B_in),
    .use_1_io_lines_in     (use_1_io_lines_in),
    .use_2_io_lines_in     (use_2_io_lines_in),
    .use_4_io_lines_in     (use_4_io_lines_in),
    .data_sample_reg_en_in (data_sample_reg_en_in),
    .sel_sample_1_line_in  (sel_sample_1_line_in),
    .io_in                 (io_in),
    .load_burst_in         (load_burst_in),
    .burst_len_in          (burst_len_in),
    .burst_count_en_in     (burst_count_en_in),
    .count_done_out        (count_done_out),
    .rx_word_out           (rx_word_out),
    .burst_comp_out        (burst_comp_out)
  );

  always #5 sclk_in = ~sclk_in;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [1:0] lim;
    logic       u1, u2, u4, a4;
    int         exp_lim;   // expected phase length in sclk cycles
  } lim_vec_t;

  lim_vec_t vecs[$];
  int       sb_q[$];      // expected done cycles for the current phase

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the
  // falling edge.
  task automatic next_cycle();
    @(posedge sclk_in);
    #1;
  endtask

  task automatic idle();
    start_count_in        = 1'b0;
    data_sample_reg_en_in = 1'b0;
    sel_sample_1_line_in  = 1'b0;
    load_burst_in         = 1'b0;
    burst_count_en_in     = 1'b0;
    next_cycle();
  endtask

  task automatic set_mode(input logic [1:0] lim, input logic u1, input logic u2,
                          input logic u4, input logic a4);
    set_count_lim_in  = lim;
    use_1_io_lines_in = u1;
    use_2_io_lines_in = u2;
    use_4_io_lines_in = u4;
    addr_of_4B_in     = a4;
  endtask

  task automatic burst_step(input logic ld, input logic [BURST_W-1:0] len, input logic en,
                            input string name, input logic exp_comp);
    load_burst_in     = ld;
    burst_len_in      = len;
    burst_count_en_in = en;
    next_cycle();
    load_burst_in     = 1'b0;
    burst_count_en_in = 1'b0;
    @(negedge sclk_in);
    check(name, {31'b0, burst_comp_out}, {31'b0, exp_comp});
  endtask

  initial begin
    logic [31:0] exp_word;
    logic [7:0]  status_bits;
    logic [3:0]  nib;
    int          done_cycles[3];
    logic        exp_done;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    set_mode(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    start_count_in = 1'b0; data_sample_reg_en_in = 1'b0; sel_sample_1_line_in = 1'b0;
    io_in = 4'h0; load_burst_in = 1'b0; burst_len_in = '0; burst_count_en_in = 1'b0;
    repeat (2) @(posedge sclk_in);
    @(negedge sclk_in);
    check("reset_done",  {31'b0, count_done_out}, 32'd0);
    check("reset_word",  rx_word_out, 32'd0);
    check("reset_bcomp", {31'b0, burst_comp_out}, 32'd1);
    rst_n = 1'b1;
    next_cycle();

    // ---------------- phase limit table ----------------
    vecs.push_back('{"cmd_1line",     2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8});
    vecs.push_back('{"cmd_quad",      2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8});
    vecs.push_back('{"addr_quad_4B",  2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8});
    vecs.push_back('{"addr_quad_3B",  2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 6});
    vecs.push_back('{"addr_dual_3B",  2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 12});
    vecs.push_back('{"addr_dual_4B",  2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 16});
    vecs.push_back('{"addr_single_4B",2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 32});
    vecs.push_back('{"addr_none_3B",  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 24});
    vecs.push_back('{"dummy",         2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 8});
    vecs.push_back('{"data_quad",     2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 8});
    vecs.push_back('{"data_dual",     2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 16});
    vecs.push_back('{"data_single",   2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32});
    vecs.push_back('{"data_quad_prio",2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 8});

    foreach (vecs[k]) begin
      idle();
      set_mode(vecs[k].lim, vecs[k].u1, vecs[k].u2, vecs[k].u4, vecs[k].a4);
      start_count_in = 1'b1;
      // Two back-to-back phases: the second done proves the counter restarts at 0.
      sb_q.push_back(vecs[k].exp_lim);
      sb_q.push_back(2 * vecs[k].exp_lim);
      for (int cyc = 1; cyc <= 80 && sb_q.size() != 0; cyc++) begin
        @(negedge sclk_in);
        if (count_done_out) check(vecs[k].name, cyc, sb_q.pop_front());
        next_cycle();
      end
      if (sb_q.size() != 0) begin
        check({vecs[k].name, "_timeout"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
      end
    end

    // ---------------- quad data sample ----------------
    idle();
    set_mode(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    start_count_in = 1'b1; data_sample_reg_en_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      io_in = 4'(i);
      @(negedge sclk_in);
      if (i == 8) check("quad_done_on_8th", {31'b0, count_done_out}, 32'd1);
      next_cycle();
    end
    start_count_in = 1'b0; data_sample_reg_en_in = 1'b0; io_in = 4'hF;
    @(negedge sclk_in);
    check("quad_word", rx_word_out, 32'h12345678);
    repeat (3) next_cycle();
    @(negedge sclk_in);
    check("quad_word_held", rx_word_out, 32'h12345678);

    // ---------------- status read: forced 1 line on io[1] ----------------
    idle();
    status_bits = 8'hA5;
    set_mode(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    start_count_in = 1'b1; data_sample_reg_en_in = 1'b1; sel_sample_1_line_in = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      io_in = {2'($urandom_range(0, 3)), status_bits[i], 1'($urandom_range(0, 1))};
      next_cycle();
    end
    start_count_in = 1'b0; data_sample_reg_en_in = 1'b0; sel_sample_1_line_in = 1'b0;
    @(negedge sclk_in);
    check("status_word", rx_word_out, 32'h000000A5);

    // ---------------- dual data with random io ----------------
    idle();
    set_mode(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    start_count_in = 1'b1; data_sample_reg_en_in = 1'b1;
    exp_word = '0;
    for (int i = 0; i < 16; i++) begin
      nib = 4'($urandom_range(0, 15));
      io_in = nib;
      exp_word = {exp_word[29:0], nib[1:0]};
      next_cycle();
    end
    start_count_in = 1'b0; data_sample_reg_en_in = 1'b0;
    @(negedge sclk_in);
    check("dual_word", rx_word_out, exp_word);

    // ---------------- burst counter ----------------
    idle();
    burst_step(1'b1, 8'd3, 1'b0, "burst_load3",  1'b0);
    burst_step(1'b0, 8'd0, 1'b1, "burst_dec1",   1'b0);
    burst_step(1'b0, 8'd0, 1'b1, "burst_dec2",   1'b0);
    burst_step(1'b0, 8'd0, 1'b1, "burst_dec3",   1'b1);
    burst_step(1'b0, 8'd0, 1'b1, "burst_sat",    1'b1);
    burst_step(1'b1, 8'd2, 1'b1, "burst_ld_prio",1'b0);
    burst_step(1'b0, 8'd0, 1'b1, "burst_prio_d1",1'b0);
    burst_step(1'b0, 8'd0, 1'b1, "burst_prio_d2",1'b1);
    burst_step(1'b1, 8'd5, 1'b0, "burst_load5",  1'b0);
    burst_step(1'b1, 8'd0, 1'b0, "burst_load0",  1'b1);

    // ---------------- mid-phase limit shortening ----------------
    idle();
    set_mode(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    start_count_in = 1'b1;
    repeat (10) next_cycle();          // cnt = 10, limit 32
    @(negedge sclk_in);
    check("lim32_not_done", {31'b0, count_done_out}, 32'd0);
    set_count_lim_in = 2'b00;          // limit 8, cnt already past 7
    #1;
    check("lim_shrink_done", {31'b0, count_done_out}, 32'd1);
    next_cycle();
    @(negedge sclk_in);
    check("lim_shrink_restart", {31'b0, count_done_out}, 32'd0);

    // ---------------- chained cmd -> addr quad 3B -> dummy ----------------
    idle();
    done_cycles = '{8, 14, 22};
    start_count_in = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      if (c <= 8)       set_mode(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (c <= 14) set_mode(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
      else              set_mode(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_done = (c == done_cycles[0]) || (c == done_cycles[1]) || (c == done_cycles[2]);
      @(negedge sclk_in);
      check($sformatf("chain_c%0d", c), {31'b0, count_done_out}, {31'b0, exp_done});
      next_cycle();
    end

    // ---------------- reset asserted mid-phase at cycle 10 ----------------
    idle();
    burst_step(1'b1, 8'd4, 1'b0, "rst_pre_bload", 1'b0);
    start_count_in = 1'b1; data_sample_reg_en_in = 1'b1; io_in = 4'hA;
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) set_mode(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      else        set_mode(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
      next_cycle();
    end
    // cycle 10 (cnt = 1 of addr phase)
    @(negedge sclk_in);
    check("rst_pre_word_nz", {31'b0, (rx_word_out != 32'd0)}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_done",  {31'b0, count_done_out}, 32'd0);
    check("rst_mid_word",  rx_word_out, 32'd0);
    check("rst_mid_bcomp", {31'b0, burst_comp_out}, 32'd1);
    idle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge sclk_in);
    check("rst_after_word", rx_word_out, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
